mem_access_unit: RTL and testbench

Load/store sequencer between the IorD address mux and the byte-addressed data memory. It latches the selected address and store data, then runs the memory read / read-modify-write sequence for word, halfword and byte accesses. It returns a zero-extended load value and flags misaligned accesses before any memory cycle is issued. The control unit starts it with a one-cycle `start` pulse and waits for `done`.

---
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the IorD address mux and byte-addressed data memory.
// Handles word/half/byte loads, read-modify-write sub-word stores and misalignment detection.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [31:0] MemData_in,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_WriteData,
    output logic        Mem_wr,
    output logic [31:0] Load_out,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [31:0] rd_q;
    logic [2:0]  op_q;
    logic [31:0] load_q;
    logic        misalign_q;

    logic        req_half;
    logic        req_word;
    logic        req_misal;
    logic [31:0] load_ext;
    logic [31:0] merge;

    // size 11 is reserved and behaves as a word access
    assign req_half  = (op[1:0] == 2'b01);
    assign req_word  = op[1];
    assign req_misal = (req_half & Address[0]) | (req_word & (Address[1:0] != 2'b00));

    always_comb begin
        load_ext = MemData_in;
        case (op_q[1:0])
            2'b00: begin
                case (addr_q[1:0])
                    2'b00:   load_ext = {24'b0, MemData_in[7:0]};
                    2'b01:   load_ext = {24'b0, MemData_in[15:8]};
                    2'b10:   load_ext = {24'b0, MemData_in[23:16]};
                    default: load_ext = {24'b0, MemData_in[31:24]};
                endcase
            end
            2'b01: begin
                if (addr_q[1])
                    load_ext = {16'b0, MemData_in[31:16]};
                else
                    load_ext = {16'b0, MemData_in[15:0]};
            end
            default: load_ext = MemData_in;
        endcase
    end

    // Sub-word store: replace the addressed lane of the word read back in WAIT
    always_comb begin
        merge = rd_q;
        if (op_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merge[7:0]   = wd_q[7:0];
                2'b01:   merge[15:8]  = wd_q[7:0];
                2'b10:   merge[23:16] = wd_q[7:0];
                default: merge[31:24] = wd_q[7:0];
            endcase
        end else begin
            if (addr_q[1])
                merge[31:16] = wd_q[15:0];
            else
                merge[15:0]  = wd_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wd_q       <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            load_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q     <= Address;
                        wd_q       <= WriteData;
                        op_q       <= op;
                        misalign_q <= req_misal;
                        if (req_misal)
                            state <= FIN;
                        else if (op[2] && req_word)
                            state <= WRITE;
                        else
                            state <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    rd_q <= MemData_in;
                    if (op_q[2]) begin
                        state <= WRITE;
                    end else begin
                        load_q <= load_ext;
                        state  <= FIN;
                    end
                end
                WRITE:   state <= FIN;
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately
    assign Mem_Address   = {addr_q[31:2], 2'b00};
    assign Mem_wr        = (state == WRITE);
    assign Mem_WriteData = (state == WRITE) ? (op_q[1] ? wd_q : merge) : '0;
    assign Load_out      = load_q;
    assign busy          = (state != IDLE);
    assign done          = (state == FIN);
    assign misalign      = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a one-cycle-latency memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] MemData_in;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_WriteData;
    logic        Mem_wr;
    logic [31:0] Load_out;
    logic        busy;
    logic        done;
    logic        misalign;

    mem_access_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .Address       (Address),
        .WriteData     (WriteData),
        .MemData_in    (MemData_in),
        .Mem_Address   (Mem_Address),
        .Mem_WriteData (Mem_WriteData),
        .Mem_wr        (Mem_wr),
        .Load_out      (Load_out),
        .busy          (busy),
        .done          (done),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    // Address sampled at the edge ending REQ; read data then stable through WAIT
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (Mem_wr)
            mem[Mem_Address[7:2]] <= Mem_WriteData;
        MemData_in <= mem[Mem_Address[7:2]];
    end

    int checks = 0;
    int errors = 0;

    int          done_cyc;
    int          done_cnt;
    int          wr_cnt;
    int          wr_cyc;
    logic [31:0] wr_data;
    logic        mis_at_done;
    logic [31:0] addr_at_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Pulses start in cycle 0, optionally re-pulses it in cycles 1..spam, and
    // returns at the negedge of the done cycle plus tail cycles (bounded at 12).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                          input int spam, input int tail);
        @(negedge clk);
        start = 1'b1; op = o; Address = a; WriteData = wd;
        done_cyc = -1; done_cnt = 0; wr_cnt = 0; wr_cyc = -1; wr_data = '0;
        mis_at_done = 1'b0; addr_at_done = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k <= spam);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = k;
                    mis_at_done  = misalign;
                    addr_at_done = Mem_Address;
                end
            end
            if (Mem_wr) begin
                wr_cnt++;
                wr_cyc  = k;
                wr_data = Mem_WriteData;
            end
            if (done_cyc > 0 && k >= done_cyc + tail) break;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; Address = '0; WriteData = '0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr", 32'(Mem_wr), 32'd0);
        check("rst_mis", 32'(misalign), 32'd0);
        check("rst_load", Load_out, 32'h0);
        check("rst_maddr", Mem_Address, 32'h0);
        check("rst_mwd", Mem_WriteData, 32'h0);
        reset = 1'b0;

        preload(6'd16, 32'hA1B2C3D4);

        run_op(3'b010, 32'h40, 32'h0, 0, 0);
        check("lw_done", 32'(done_cyc), 32'd3);
        check("lw_nowr", 32'(wr_cnt), 32'd0);
        check("lw_val", Load_out, 32'hA1B2C3D4);
        check("lw_addr", addr_at_done, 32'h40);
        check("lw_mis", 32'(mis_at_done), 32'd0);

        run_op(3'b000, 32'h42, 32'h0, 0, 0);
        check("lb42_done", 32'(done_cyc), 32'd3);
        check("lb42_val", Load_out, 32'h000000B2);
        run_op(3'b001, 32'h42, 32'h0, 0, 0);
        check("lh42_val", Load_out, 32'h0000A1B2);
        run_op(3'b000, 32'h43, 32'h0, 0, 0);
        check("lb43_val", Load_out, 32'h000000A1);

        run_op(3'b100, 32'h41, 32'h12345678, 0, 0);
        check("sb_done", 32'(done_cyc), 32'd4);
        check("sb_wrcnt", 32'(wr_cnt), 32'd1);
        check("sb_wrcyc", 32'(wr_cyc), 32'd3);
        check("sb_wdata", wr_data, 32'hA1B278D4);
        check("sb_mem", mem[16], 32'hA1B278D4);
        check("sb_load_hold", Load_out, 32'h000000A1);

        preload(6'd16, 32'hA1B2C3D4);
        run_op(3'b101, 32'h42, 32'h12345678, 0, 0);
        check("sh_done", 32'(done_cyc), 32'd4);
        check("sh_wdata", wr_data, 32'h5678C3D4);
        check("sh_mem", mem[16], 32'h5678C3D4);

        run_op(3'b010, 32'h41, 32'h0, 0, 0);
        check("mis_lw_done", 32'(done_cyc), 32'd1);
        check("mis_lw_flag", 32'(mis_at_done), 32'd1);
        check("mis_lw_nowr", 32'(wr_cnt), 32'd0);
        check("mis_lw_load", Load_out, 32'h000000A1);

        run_op(3'b101, 32'h43, 32'h0000FFFF, 0, 2);
        check("mis_sh_done", 32'(done_cyc), 32'd1);
        check("mis_sh_flag", 32'(mis_at_done), 32'd1);
        check("mis_sh_nowr", 32'(wr_cnt), 32'd0);
        check("mis_sh_mem", mem[16], 32'h5678C3D4);
        check("mis_hold", 32'(misalign), 32'd1);

        run_op(3'b011, 32'h42, 32'h0, 0, 0);
        check("mis_rsv_flag", 32'(mis_at_done), 32'd1);

        run_op(3'b010, 32'h40, 32'h0, 0, 0);
        check("mis_clr", 32'(mis_at_done), 32'd0);
        check("mis_clr_val", Load_out, 32'h5678C3D4);

        run_op(3'b000, 32'h40, 32'h0, 2, 3);
        check("busy_done", 32'(done_cyc), 32'd3);
        check("busy_dcnt", 32'(done_cnt), 32'd1);
        check("busy_val", Load_out, 32'h000000D4);

        run_op(3'b110, 32'h44, 32'hCAFEF00D, 0, 0);
        check("sw_done", 32'(done_cyc), 32'd2);
        check("sw_wrcyc", 32'(wr_cyc), 32'd1);
        check("sw_wdata", wr_data, 32'hCAFEF00D);
        run_op(3'b111, 32'h48, 32'h0BADBEEF, 0, 0);
        check("b2b_done", 32'(done_cyc), 32'd2);
        check("b2b_wrcyc", 32'(wr_cyc), 32'd1);
        check("b2b_mem0", mem[17], 32'hCAFEF00D);
        check("b2b_mem1", mem[18], 32'h0BADBEEF);

        @(negedge clk);
        start = 1'b1; op = 3'b100; Address = 32'h40; WriteData = 32'h000000EE;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rmid_wr_pre", 32'(Mem_wr), 32'd1);
        reset = 1'b1;
        #1;
        check("rmid_wr", 32'(Mem_wr), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_mwd", Mem_WriteData, 32'h0);
        check("rmid_load", Load_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rmid_mem", mem[16], 32'h5678C3D4);

        run_op(3'b010, 32'h40, 32'h0, 0, 0);
        check("post_done", 32'(done_cyc), 32'd3);
        check("post_val", Load_out, 32'h5678C3D4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
